// File: rtl/cmd_ctrl_p.sv
// cmd_ctrl_p: UART command controller with frame assembly, execute
// handshake, busy-gated response streaming, timeouts and status.
// Ports:
//   clk, nRst            clock, async active-low reset
//   rx_data/rx_valid     received byte strobe; rx_get accepts it in LOAD
//   cmd_addr/opcode/payload  last completed frame (byte0, byte1, rest)
//   exec_start/exec_done execute pulse out, completion strobe in
//   sel/resp_data        result byte index out, selected result byte in
//   tx_data/tx_send      transmit byte and one-cycle request
//   tx_busy              transmitter busy
//   status               last outcome (AA reset, 00 ok, E1 rx, E2 exec)
//   idle                 LOAD with no partial frame
module cmd_ctrl_p #(
    parameter int FRAME_BYTES  = 6,
    parameter int RESP_BYTES   = 16,
    parameter int SEL_W        = 4,
    parameter int RX_TIMEOUT   = 1000000,
    parameter int EXEC_TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_get,
    output logic [7:0]                  cmd_addr,
    output logic [7:0]                  cmd_opcode,
    output logic [8*(FRAME_BYTES-2)-1:0] cmd_payload,
    output logic                        exec_start,
    input  logic                        exec_done,
    output logic [SEL_W-1:0]            sel,
    input  logic [7:0]                  resp_data,
    output logic [7:0]                  tx_data,
    output logic                        tx_send,
    input  logic                        tx_busy,
    output logic [7:0]                  status,
    output logic                        idle
);

    localparam int CNT_W = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;
    localparam int RT_W  = $clog2(RX_TIMEOUT + 1);
    localparam int ET_W  = $clog2(EXEC_TIMEOUT + 1);
    localparam int BUF_W = 8 * (FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        EXEC      = 2'd1,
        RESP_SEND = 2'd2,
        RESP_GAP  = 2'd3
    } state_e;

    state_e                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [RT_W-1:0]              rt_q;
    logic [ET_W-1:0]              et_q;
    logic [BUF_W-1:0]             buf_q;
    logic [7:0]                   addr_q;
    logic [7:0]                   opcode_q;
    logic [8*(FRAME_BYTES-2)-1:0] payload_q;
    logic                         start_q;
    logic [SEL_W-1:0]             sel_q;
    logic [7:0]                   txd_q;
    logic                         send_q;
    logic [7:0]                   status_q;

    // Completed frame: buffered bytes plus the byte arriving now on top.
    logic [8*FRAME_BYTES-1:0] frame_d;
    logic                     last_byte;

    always_comb begin
        frame_d   = {rx_data, buf_q};
        last_byte = (cnt_q == CNT_W'(FRAME_BYTES - 1));
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            rt_q      <= '0;
            et_q      <= '0;
            buf_q     <= '0;
            addr_q    <= '0;
            opcode_q  <= '0;
            payload_q <= '0;
            start_q   <= 1'b0;
            sel_q     <= '0;
            txd_q     <= '0;
            send_q    <= 1'b0;
            status_q  <= 8'hAA;
        end else begin
            start_q <= 1'b0;
            send_q  <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (rx_valid) begin
                        rt_q <= '0;
                        if (last_byte) begin
                            addr_q    <= frame_d[7:0];
                            opcode_q  <= frame_d[15:8];
                            payload_q <= frame_d[8*FRAME_BYTES-1:16];
                            cnt_q     <= '0;
                            et_q      <= '0;
                            start_q   <= 1'b1;
                            state_q   <= EXEC;
                        end else begin
                            for (int i = 0; i < FRAME_BYTES - 1; i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    buf_q[8*i +: 8] <= rx_data;
                                end
                            end
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (cnt_q != '0) begin
                        // Stalled partial frame: drop it once the gap expires.
                        if (rt_q >= RT_W'(RX_TIMEOUT - 1)) begin
                            cnt_q    <= '0;
                            rt_q     <= '0;
                            status_q <= 8'hE1;
                        end else begin
                            rt_q <= rt_q + RT_W'(1);
                        end
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (opcode_q[7]) begin
                            status_q <= 8'h00;
                            state_q  <= LOAD;
                        end else begin
                            sel_q   <= '0;
                            state_q <= RESP_SEND;
                        end
                    end else if (et_q >= ET_W'(EXEC_TIMEOUT - 1)) begin
                        status_q <= 8'hE2;
                        state_q  <= LOAD;
                    end else begin
                        et_q <= et_q + ET_W'(1);
                    end
                end
                RESP_SEND: begin
                    if (!tx_busy) begin
                        txd_q   <= resp_data;
                        send_q  <= 1'b1;
                        state_q <= RESP_GAP;
                    end
                end
                RESP_GAP: begin
                    // One dead cycle so tx_busy has risen before resampling.
                    if (sel_q >= SEL_W'(RESP_BYTES - 1)) begin
                        sel_q    <= '0;
                        status_q <= 8'h00;
                        state_q  <= LOAD;
                    end else begin
                        sel_q   <= sel_q + SEL_W'(1);
                        state_q <= RESP_SEND;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign rx_get      = rx_valid && (state_q == LOAD);
    assign cmd_addr    = addr_q;
    assign cmd_opcode  = opcode_q;
    assign cmd_payload = payload_q;
    assign exec_start  = start_q;
    assign sel         = sel_q;
    assign tx_data     = txd_q;
    assign tx_send     = send_q;
    assign status      = status_q;
    assign idle        = (state_q == LOAD) && (cnt_q == '0);

endmodule

// File: tb/tb_cmd_ctrl_p.sv
// tb_cmd_ctrl_p: directed bench for cmd_ctrl_p, two instances
// (16 and 4 result bytes) sharing rx/exec stimulus.
module tb_cmd_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nRst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       exec_done;
    logic       hold;

    logic        rx_get_a, exec_start_a, tx_send_a, idle_a;
    logic [7:0]  cmd_addr_a, cmd_opcode_a, tx_data_a, status_a, resp_data_a;
    logic [31:0] cmd_payload_a;
    logic [3:0]  sel_a;
    logic        tx_busy_a = 1'b0;

    logic        rx_get_b, exec_start_b, tx_send_b, idle_b;
    logic [7:0]  cmd_addr_b, cmd_opcode_b, tx_data_b, status_b, resp_data_b;
    logic [31:0] cmd_payload_b;
    logic [1:0]  sel_b;
    logic        tx_busy_b = 1'b0;

    function automatic logic [7:0] rdat(input int i);
        return 8'hA5 ^ 8'(i * 17);
    endfunction

    assign resp_data_a = rdat(int'(sel_a));
    assign resp_data_b = rdat(int'(sel_b));

    cmd_ctrl_p #(
        .FRAME_BYTES(6), .RESP_BYTES(16), .SEL_W(4),
        .RX_TIMEOUT(50), .EXEC_TIMEOUT(32)
    ) u_a (
        .clk(clk), .nRst(nRst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_get(rx_get_a), .cmd_addr(cmd_addr_a), .cmd_opcode(cmd_opcode_a),
        .cmd_payload(cmd_payload_a), .exec_start(exec_start_a),
        .exec_done(exec_done), .sel(sel_a), .resp_data(resp_data_a),
        .tx_data(tx_data_a), .tx_send(tx_send_a), .tx_busy(tx_busy_a),
        .status(status_a), .idle(idle_a)
    );

    cmd_ctrl_p #(
        .FRAME_BYTES(6), .RESP_BYTES(4), .SEL_W(2),
        .RX_TIMEOUT(50), .EXEC_TIMEOUT(32)
    ) u_b (
        .clk(clk), .nRst(nRst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_get(rx_get_b), .cmd_addr(cmd_addr_b), .cmd_opcode(cmd_opcode_b),
        .cmd_payload(cmd_payload_b), .exec_start(exec_start_b),
        .exec_done(exec_done), .sel(sel_b), .resp_data(resp_data_b),
        .tx_data(tx_data_b), .tx_send(tx_send_b), .tx_busy(tx_busy_b),
        .status(status_b), .idle(idle_b)
    );

    // UART transmitter models: busy for 20 cycles after each send.
    int bcnt_a = 0;
    int bcnt_b = 0;
    always @(negedge clk) begin
        if (tx_send_a) bcnt_a = 20;
        else if (bcnt_a > 0) bcnt_a--;
        tx_busy_a = hold || (bcnt_a != 0);
        if (tx_send_b) bcnt_b = 20;
        else if (bcnt_b > 0) bcnt_b--;
        tx_busy_b = hold || (bcnt_b != 0);
    end

    // Send monitors: count sends, flag wrong data/index or send while busy.
    int sends_a = 0, bad_a = 0, starts_a = 0, idx_a = 0;
    int sends_b = 0, bad_b = 0, idx_b = 0;
    logic pb_a = 1'b0, pb_b = 1'b0;
    always @(posedge clk) begin
        if (!nRst) begin
            idx_a = 0;
            idx_b = 0;
        end else begin
            if (exec_start_a) starts_a++;
            if (tx_send_a) begin
                sends_a++;
                if (pb_a || tx_data_a !== rdat(idx_a) || int'(sel_a) != idx_a)
                    bad_a++;
                idx_a = (idx_a + 1) % 16;
            end
            if (tx_send_b) begin
                sends_b++;
                if (pb_b || tx_data_b !== rdat(idx_b) || int'(sel_b) != idx_b)
                    bad_b++;
                idx_b = (idx_b + 1) % 4;
            end
        end
        pb_a = tx_busy_a;
        pb_b = tx_busy_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, o, p0, p1, p2, p3);
        send_byte(a);
        send_byte(o);
        send_byte(p0);
        send_byte(p1);
        send_byte(p2);
        send_byte(p3);
    endtask

    task automatic pulse_done();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (idle_a && idle_b) break;
            tick();
        end
    endtask

    int n0, b0, s0, nb, bb;

    initial begin
        nRst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        exec_done = 1'b0; hold = 1'b0;
        repeat (3) tick();
        chk("rst_status", status_a, 32'hAA);
        chk("rst_idle", idle_a, 32'h1);
        chk("rst_addr", cmd_addr_a, 32'h0);
        chk("rst_payload", cmd_payload_a, 32'h0);
        chk("rst_sel", sel_a, 32'h0);
        chk("rst_tx_send", tx_send_a, 32'h0);
        chk("rst_tx_data", tx_data_a, 32'h0);
        chk("rst_exec_start", exec_start_a, 32'h0);
        nRst = 1'b1;
        tick();

        // 1: normal frame, 16-byte response
        s0 = starts_a; n0 = sends_a; b0 = bad_a;
        rx_data = 8'h03; rx_valid = 1'b1;
        #1 chk("t1_rx_get", rx_get_a, 32'h1);
        tick();
        rx_valid = 1'b0;
        chk("t1_idle_low", idle_a, 32'h0);
        send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        chk("t1_exec_start", exec_start_a, 32'h1);
        chk("t1_addr", cmd_addr_a, 32'h03);
        chk("t1_opcode", cmd_opcode_a, 32'h02);
        chk("t1_payload", cmd_payload_a, 32'h44332211);
        repeat (10) tick();
        pulse_done();
        wait_idle(2000);
        chk("t1_sends", sends_a - n0, 32'd16);
        chk("t1_send_errs", bad_a - b0, 32'd0);
        chk("t1_starts", starts_a - s0, 32'd1);
        chk("t1_status", status_a, 32'h00);
        chk("t1_sel", sel_a, 32'h0);

        // 2: write-only opcode
        n0 = sends_a;
        send_frame(8'h07, 8'h85, 8'h01, 8'h02, 8'h03, 8'h04);
        chk("t2_opcode", cmd_opcode_a, 32'h85);
        repeat (3) tick();
        pulse_done();
        repeat (5) tick();
        chk("t2_sends", sends_a - n0, 32'd0);
        chk("t2_status", status_a, 32'h00);
        chk("t2_idle", idle_a, 32'h1);

        // 3: inter-byte timeout then a good frame
        n0 = sends_a; b0 = bad_a;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        repeat (49) tick();
        chk("t3_pre_status", status_a, 32'h00);
        chk("t3_pre_idle", idle_a, 32'h0);
        tick();
        chk("t3_status", status_a, 32'hE1);
        chk("t3_idle", idle_a, 32'h1);
        chk("t3_addr_kept", cmd_addr_a, 32'h07);
        chk("t3_opc_kept", cmd_opcode_a, 32'h85);
        chk("t3_pay_kept", cmd_payload_a, 32'h04030201);
        send_frame(8'h05, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        chk("t3_addr", cmd_addr_a, 32'h05);
        chk("t3_payload", cmd_payload_a, 32'hDDCCBBAA);
        repeat (2) tick();
        pulse_done();
        wait_idle(2000);
        chk("t3_sends", sends_a - n0, 32'd16);
        chk("t3_send_errs", bad_a - b0, 32'd0);
        chk("t3_status_ok", status_a, 32'h00);

        // 4: execute timeout
        send_frame(8'h09, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04);
        n0 = sends_a;
        repeat (5) tick();
        rx_data = 8'h55; rx_valid = 1'b1;
        #1 chk("t4_rx_get_exec", rx_get_a, 32'h0);
        tick();
        rx_valid = 1'b0;
        repeat (25) tick();
        chk("t4_pre_status", status_a, 32'h00);
        chk("t4_pre_idle", idle_a, 32'h0);
        tick();
        chk("t4_status", status_a, 32'hE2);
        chk("t4_idle", idle_a, 32'h1);
        chk("t4_sends", sends_a - n0, 32'd0);
        rx_data = 8'h0B; rx_valid = 1'b1;
        #1 chk("t4_rx_get_load", rx_get_a, 32'h1);
        tick();
        rx_valid = 1'b0;

        // 5: backpressure on the 4-byte instance
        hold = 1'b1;
        nb = sends_b; bb = bad_b;
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h30); send_byte(8'h40);
        chk("t5_addr", cmd_addr_b, 32'h0B);
        chk("t5_payload", cmd_payload_b, 32'h40302010);
        repeat (2) tick();
        pulse_done();
        repeat (100) tick();
        chk("t5_no_send_busy", sends_b - nb, 32'd0);
        chk("t5_sel_hold", sel_b, 32'h0);
        hold = 1'b0;
        wait_idle(2000);
        chk("t5_sends", sends_b - nb, 32'd4);
        chk("t5_send_errs", bad_b - bb, 32'd0);
        chk("t5_sel_end", sel_b, 32'h0);
        chk("t5_status", status_b, 32'h00);

        // 6: reset during the fifth response byte
        n0 = sends_a;
        send_frame(8'h0C, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04);
        repeat (2) tick();
        pulse_done();
        for (int i = 0; i < 2000; i++) begin
            if (sends_a - n0 == 4 && tx_send_a) break;
            tick();
        end
        chk("t6_fifth_send", tx_send_a, 32'h1);
        #1 nRst = 1'b0;
        #1;
        chk("t6_tx_send", tx_send_a, 32'h0);
        chk("t6_status", status_a, 32'hAA);
        chk("t6_idle", idle_a, 32'h1);
        chk("t6_sel", sel_a, 32'h0);
        chk("t6_addr", cmd_addr_a, 32'h0);
        chk("t6_tx_data", tx_data_a, 32'h0);
        repeat (2) tick();
        nRst = 1'b1;
        tick();
        n0 = sends_a; b0 = bad_a;
        send_frame(8'h0D, 8'h02, 8'h05, 8'h06, 8'h07, 8'h08);
        chk("t6_new_start", exec_start_a, 32'h1);
        chk("t6_new_addr", cmd_addr_a, 32'h0D);
        chk("t6_new_payload", cmd_payload_a, 32'h08070605);
        repeat (2) tick();
        pulse_done();
        wait_idle(2000);
        chk("t6_sends", sends_a - n0, 32'd16);
        chk("t6_send_errs", bad_a - b0, 32'd0);
        chk("t6_status_ok", status_a, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
